// File: rtl/collision_mixer_pkg.sv
// Shared definitions for the collision mixer slice: colour-word layout,
// hit-stretch FSM encoding, default timing parameters and the saturating
// 4-digit BCD increment used by the score counter.
package collision_mixer_pkg;

  // Colour word is {rgb[23:0], valid}
  localparam int COLOR_W   = 25;
  localparam int VALID_BIT = 0;

  localparam int DEFAULT_V_ACTIVE    = 1080;
  localparam int DEFAULT_HIT_STRETCH = 8;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_STRETCH = 1'b1
  } hit_state_e;

  // Next value of a 4-digit BCD number; holds at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    if (value == 16'h9999) begin
      result = value;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (result[4*d +: 4] == 4'd9) begin
            result[4*d +: 4] = 4'd0;
            carry            = 1'b1;
          end else begin
            result[4*d +: 4] = result[4*d +: 4] + 4'd1;
            carry            = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// 4-digit saturating BCD counter.
// Ports:
//   clock    - system clock
//   reset    - synchronous active-high reset, clears count to 0000
//   inc_i    - increment by one BCD step this clock
//   count_o  - current count, 4 BCD digits
module bcd_counter4
  import collision_mixer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: step on request, otherwise hold
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = bcd_inc_sat(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/collision_mixer.sv
// Sprite compositor and collision detector.
// Composites ship > bullet > enemy > background into a registered pixel,
// detects bullet/enemy and ship/enemy overlap on visible pixels, stretches
// the bullet-removal request to HIT_STRETCH clocks, keeps a BCD score and a
// sticky ship-destroyed flag, and flags vertical blanking as the update window.
// Ports:
//   clock, reset         - system clock, synchronous active-high reset
//   display_col/row      - current pixel position
//   display_enable       - active-video qualifier
//   bullet/enemy/ship_color - {rgb, valid} sprite layers
//   bg_color             - background rgb
//   pixel_out            - composited rgb, 1 clock latency
//   hit                  - bullet-removal request, HIT_STRETCH clocks wide
//   enemy_hit, ship_hit  - single-clock event pulses
//   ship_dead            - sticky ship-destroyed flag
//   score                - 4-digit BCD score
//   calc                 - high during vertical blanking
module collision_mixer
  import collision_mixer_pkg::*;
#(
  parameter int V_ACTIVE    = DEFAULT_V_ACTIVE,
  parameter int HIT_STRETCH = DEFAULT_HIT_STRETCH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        display_col,
  input  logic [10:0]        display_row,
  input  logic               display_enable,
  input  logic [COLOR_W-1:0] bullet_color,
  input  logic [COLOR_W-1:0] enemy_color,
  input  logic [COLOR_W-1:0] ship_color,
  input  logic [23:0]        bg_color,
  output logic [23:0]        pixel_out,
  output logic               hit,
  output logic               enemy_hit,
  output logic               ship_hit,
  output logic               ship_dead,
  output logic [15:0]        score,
  output logic               calc
);

  localparam int               CNT_W    = (HIT_STRETCH > 1) ? $clog2(HIT_STRETCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HIT_STRETCH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [10:0]      V_ROW    = 11'(V_ACTIVE);

  hit_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [23:0] pixel_q, pixel_d;
  logic        hit_q, hit_d;
  logic        enemy_hit_q, enemy_hit_d;
  logic        ship_hit_q, ship_hit_d;
  logic        ship_dead_q, ship_dead_d;
  logic        calc_q, calc_d;
  logic        score_en_s;

  logic blank_s, eval_s, bullet_coll_s, ship_coll_s, start_s;

  // Column does not affect compositing; sprite stages already resolved position
  logic unused_col_s;
  assign unused_col_s = ^display_col;

  assign blank_s       = (display_row >= V_ROW);
  assign eval_s        = display_enable & ~blank_s;
  assign bullet_coll_s = eval_s & bullet_color[VALID_BIT] & enemy_color[VALID_BIT];
  assign ship_coll_s   = eval_s & ship_color[VALID_BIT] & enemy_color[VALID_BIT];

  // FSM state and stretch counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: blanking forces IDLE so hit drops as calc rises
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (blank_s) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bullet_coll_s) begin
            state_d = ST_STRETCH;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_STRETCH: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode; a bullet collision scores only with a live ship that
  // is not being hit on the same pixel
  always_comb begin
    start_s     = (state_q == ST_IDLE) & bullet_coll_s;
    hit_d       = (state_d == ST_STRETCH);
    score_en_s  = start_s & ~ship_dead_q & ~ship_coll_s;
    enemy_hit_d = score_en_s;
    ship_hit_d  = ship_coll_s & ~ship_dead_q;
    ship_dead_d = ship_dead_q | ship_coll_s;
    calc_d      = blank_s;
    if (!eval_s) begin
      pixel_d = 24'h000000;
    end else if (ship_color[VALID_BIT]) begin
      pixel_d = ship_color[COLOR_W-1:1];
    end else if (bullet_color[VALID_BIT]) begin
      pixel_d = bullet_color[COLOR_W-1:1];
    end else if (enemy_color[VALID_BIT]) begin
      pixel_d = enemy_color[COLOR_W-1:1];
    end else begin
      pixel_d = bg_color;
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_q     <= 24'h000000;
      hit_q       <= 1'b0;
      enemy_hit_q <= 1'b0;
      ship_hit_q  <= 1'b0;
      ship_dead_q <= 1'b0;
      calc_q      <= 1'b0;
    end else begin
      pixel_q     <= pixel_d;
      hit_q       <= hit_d;
      enemy_hit_q <= enemy_hit_d;
      ship_hit_q  <= ship_hit_d;
      ship_dead_q <= ship_dead_d;
      calc_q      <= calc_d;
    end
  end

  bcd_counter4 u_score (
    .clock   (clock),
    .reset   (reset),
    .inc_i   (score_en_s),
    .count_o (score)
  );

  assign pixel_out = pixel_q;
  assign hit       = hit_q;
  assign enemy_hit = enemy_hit_q;
  assign ship_hit  = ship_hit_q;
  assign ship_dead = ship_dead_q;
  assign calc      = calc_q;

endmodule

// File: tb/tb_collision_mixer.sv
// Scoreboard bench for collision_mixer: the driver pushes the hand-computed
// outputs expected after each clock; a monitor pops and compares them.
// A second instance with HIT_STRETCH=1 runs into score saturation.
module tb_collision_mixer;

  localparam logic [23:0] BUL = 24'h00FF00;
  localparam logic [23:0] ENE = 24'hFF0000;
  localparam logic [23:0] SHP = 24'h0000FF;
  localparam logic [23:0] BG  = 24'h101010;
  localparam logic [23:0] BG2 = 24'hABCDEF;

  logic        clock;
  logic        reset;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        display_enable;
  logic [24:0] bullet_color, enemy_color, ship_color;
  logic [23:0] bg_color;
  logic [23:0] pixel_out;
  logic        hit, enemy_hit, ship_hit, ship_dead, calc;
  logic [15:0] score;

  logic        reset2;
  logic [11:0] col2;
  logic [10:0] row2;
  logic        en2;
  logic [24:0] bul2, ene2, shp2;
  logic [23:0] bg2_in;
  logic [23:0] pix2;
  logic        hit2, ehit2, shit2, dead2, calc2;
  logic [15:0] score2;

  typedef struct packed {
    logic [23:0] pix;
    logic        hit;
    logic        eh;
    logic        sh;
    logic        dead;
    logic [15:0] score;
    logic        calc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   mon_n;
  int   checks;
  int   passes;

  logic [23:0] e_pix;
  logic        e_hit, e_eh, e_sh, e_dead, e_calc;
  logic [15:0] e_score;

  logic sat_done;
  int   sat_n, sat_after;
  logic [15:0] e38 [3];

  collision_mixer dut (
    .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
    .display_enable(display_enable), .bullet_color(bullet_color), .enemy_color(enemy_color),
    .ship_color(ship_color), .bg_color(bg_color), .pixel_out(pixel_out), .hit(hit),
    .enemy_hit(enemy_hit), .ship_hit(ship_hit), .ship_dead(ship_dead), .score(score), .calc(calc)
  );

  collision_mixer #(.V_ACTIVE(1080), .HIT_STRETCH(1)) dut_sat (
    .clock(clock), .reset(reset2), .display_col(col2), .display_row(row2),
    .display_enable(en2), .bullet_color(bul2), .enemy_color(ene2),
    .ship_color(shp2), .bg_color(bg2_in), .pixel_out(pix2), .hit(hit2),
    .enemy_hit(ehit2), .ship_hit(shit2), .ship_dead(dead2), .score(score2), .calc(calc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) begin
      passes++;
    end else begin
      $display("FAIL %s (step %0d): got %h, expected %h", name, tag, act, req);
    end
  endtask

  task automatic layers(input logic b, input logic e, input logic s);
    bullet_color = {BUL, b};
    enemy_color  = {ENE, e};
    ship_color   = {SHP, s};
  endtask

  // Push the outputs expected after the coming clock edge, then advance
  task automatic tick();
    exp_t x;
    x.pix = e_pix; x.hit = e_hit; x.eh = e_eh; x.sh = e_sh;
    x.dead = e_dead; x.score = e_score; x.calc = e_calc;
    exp_q.push_back(x);
    e_eh = 1'b0;
    e_sh = 1'b0;
    display_col = display_col + 12'd1;
    @(negedge clock);
  endtask

  // Monitor: every registered output is presented one clock after its inputs
  initial begin
    mon_n = 0;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        mon_x = exp_q.pop_front();
        mon_n++;
        chk("pixel_out", mon_n, 32'(pixel_out), 32'(mon_x.pix));
        chk("hit",       mon_n, 32'(hit),       32'(mon_x.hit));
        chk("enemy_hit", mon_n, 32'(enemy_hit), 32'(mon_x.eh));
        chk("ship_hit",  mon_n, 32'(ship_hit),  32'(mon_x.sh));
        chk("ship_dead", mon_n, 32'(ship_dead), 32'(mon_x.dead));
        chk("score",     mon_n, 32'(score),     32'(mon_x.score));
        chk("calc",      mon_n, 32'(calc),      32'(mon_x.calc));
      end
    end
  end

  // Saturation run: continuous collisions, one scored hit every two clocks
  initial begin
    sat_done = 1'b0;
    sat_n = 0;
    sat_after = 0;
    reset2 = 1'b1; col2 = 12'd0; row2 = 11'd100; en2 = 1'b1;
    bul2 = {BUL, 1'b1}; ene2 = {ENE, 1'b1}; shp2 = {SHP, 1'b0}; bg2_in = BG;
    repeat (3) @(negedge clock);
    reset2 = 1'b0;
    for (int c = 0; c < 20040; c++) begin
      @(negedge clock);
      if (sat_n >= 9999 && hit2) sat_after++;
      if (ehit2) begin
        sat_n++;
        if (sat_n == 10)   chk("score_bcd_10",   sat_n, 32'(score2), 32'h0010);
        if (sat_n == 100)  chk("score_bcd_100",  sat_n, 32'(score2), 32'h0100);
        if (sat_n == 1000) chk("score_bcd_1000", sat_n, 32'(score2), 32'h1000);
        if (sat_n == 9999) chk("score_bcd_9999", sat_n, 32'(score2), 32'h9999);
      end
    end
    chk("score_saturated", sat_n, 32'(score2), 32'h9999);
    chk("hit_after_saturation", sat_after, 32'(sat_after >= 5), 32'd1);
    sat_done = 1'b1;
  end

  initial begin
    checks = 0; passes = 0;
    e38[0] = 16'h0002; e38[1] = 16'h0003; e38[2] = 16'h0004;
    reset = 1'b1; display_col = 12'd0; display_row = 11'd100; display_enable = 1'b1;
    bg_color = BG; layers(1'b0, 1'b0, 1'b0);
    e_pix = 24'h0; e_hit = 1'b0; e_eh = 1'b0; e_sh = 1'b0; e_dead = 1'b0;
    e_score = 16'h0000; e_calc = 1'b0;
    @(negedge clock);

    // Reset dominates colliding inputs
    layers(1'b1, 1'b1, 1'b1); tick(); tick();
    reset = 1'b0; layers(1'b0, 1'b0, 1'b0); e_pix = BG; tick();

    // Single-clock bullet collision: 8-clock hit, score 0001
    layers(1'b1, 1'b1, 1'b0); e_pix = BUL; e_hit = 1'b1; e_eh = 1'b1; e_score = 16'h0001; tick();
    layers(1'b0, 1'b0, 1'b0); e_pix = BG; repeat (7) tick();
    e_hit = 1'b0; tick();

    // Layer priority and the display_enable gate
    layers(1'b1, 1'b0, 1'b1); e_pix = SHP; tick();
    layers(1'b1, 1'b0, 1'b0); e_pix = BUL; tick();
    layers(1'b0, 1'b1, 1'b0); e_pix = ENE; tick();
    layers(1'b0, 1'b0, 1'b0); bg_color = BG2; e_pix = BG2; tick();
    bg_color = BG; display_enable = 1'b0; layers(1'b1, 1'b1, 1'b1); e_pix = 24'h0; tick();
    display_enable = 1'b1; layers(1'b0, 1'b0, 1'b0); e_pix = BG; tick();

    // 20 consecutive collision clocks: pulses start at clocks 0, 9, 18
    layers(1'b1, 1'b1, 1'b0); e_pix = BUL;
    for (int k = 0; k < 20; k++) begin
      e_hit = ((k % 9) != 8);
      if ((k % 9) == 0) begin
        e_eh = 1'b1;
        e_score = e38[k / 9];
      end
      tick();
    end
    layers(1'b0, 1'b0, 1'b0); e_pix = BG; e_hit = 1'b1; repeat (6) tick();
    e_hit = 1'b0; tick();

    // Blanking entered mid-stretch drops hit; blank-row collisions ignored
    display_row = 11'd1079; layers(1'b1, 1'b1, 1'b0); e_pix = BUL; e_hit = 1'b1;
    e_eh = 1'b1; e_score = 16'h0005; tick();
    layers(1'b0, 1'b0, 1'b0); e_pix = BG; tick(); tick();
    display_row = 11'd1080; layers(1'b1, 1'b1, 1'b0); e_pix = 24'h0; e_hit = 1'b0; e_calc = 1'b1;
    tick(); tick();
    display_row = 11'd1124; layers(1'b1, 1'b1, 1'b1); tick();
    display_row = 11'd0; layers(1'b0, 1'b0, 1'b0); e_pix = BG; e_calc = 1'b0; tick();
    display_row = 11'd5; tick();

    // Reset in the middle of a stretch
    display_row = 11'd200; layers(1'b1, 1'b1, 1'b0); e_pix = BUL; e_hit = 1'b1;
    e_eh = 1'b1; e_score = 16'h0006; tick();
    layers(1'b0, 1'b0, 1'b0); e_pix = BG; tick(); tick();
    reset = 1'b1; e_pix = 24'h0; e_hit = 1'b0; e_score = 16'h0000; tick();
    reset = 1'b0; e_pix = BG; tick();

    // Ship collision, repeat ignored, then an unscored bullet collision
    layers(1'b0, 1'b1, 1'b1); e_pix = SHP; e_sh = 1'b1; e_dead = 1'b1; tick();
    tick();
    layers(1'b1, 1'b1, 1'b0); e_pix = BUL; e_hit = 1'b1; tick();
    layers(1'b0, 1'b0, 1'b0); e_pix = BG; repeat (7) tick();
    e_hit = 1'b0; tick();

    // Simultaneous bullet and ship collision on a fresh ship
    reset = 1'b1; e_pix = 24'h0; e_dead = 1'b0; tick();
    reset = 1'b0; e_pix = BG; tick();
    layers(1'b1, 1'b1, 1'b1); e_pix = SHP; e_hit = 1'b1; e_sh = 1'b1; e_dead = 1'b1; tick();
    layers(1'b0, 1'b0, 1'b0); e_pix = BG; repeat (7) tick();
    e_hit = 1'b0; tick();

    @(negedge clock);
    chk("scoreboard_drained", mon_n, 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 25000 && !sat_done; i++) @(negedge clock);
    chk("saturation_run_done", sat_n, 32'(sat_done), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
